// File: rtl/spi_slave_word.sv
// SPI slave moving WIDTH-bit words full-duplex in any of the four SPI modes.
// The pins are oversampled in the clk domain. Received words come out as
// a one-cycle strobe. Transmit words go through a one-deep holding register.
module spi_slave_word #(
    parameter int WIDTH       = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int MSB_FIRST   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             underrun,
    output logic             frame_abort,
    output logic             busy
);
    localparam int   CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic IDLE_L = (CPOL != 0);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic sclk_dly_q, cs_dly_q;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d, hold_q, hold_d;
    logic full_q, full_d, fresh_q, fresh_d;
    logic miso_q, miso_d, oe_q, oe_d;
    logic rxv_q, rxv_d, und_q, und_d, abt_q, abt_d;

    logic sclk_s, cs_s, mosi_s;
    logic lead_e, trail_e, sample_e, launch_e, cs_fall, cs_rise;
    logic reload;
    logic [WIDTH-1:0] tx_src, tx_shifted, rx_shifted;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Pin synchronisers plus a one-cycle delayed copy for edge detection.
    // The CS_N chain resets low, so after reset a held-low CS_N does not look
    // like a falling edge. A new frame then needs CS_N to go high and low again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= {SYNC_STAGES{IDLE_L}};
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= IDLE_L;
            cs_dly_q    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign lead_e   = (sclk_s != IDLE_L) && (sclk_dly_q == IDLE_L);
    assign trail_e  = (sclk_s == IDLE_L) && (sclk_dly_q != IDLE_L);
    assign sample_e = (CPHA != 0) ? trail_e : lead_e;
    assign launch_e = (CPHA != 0) ? lead_e : trail_e;
    assign cs_fall  = !cs_s && cs_dly_q;
    assign cs_rise  = cs_s && !cs_dly_q;

    assign tx_src     = full_q ? hold_q : '0;
    assign tx_shifted = advance(tx_sh_q);
    assign rx_shifted = (MSB_FIRST != 0) ? {rx_sh_q[WIDTH-2:0], mosi_s}
                                         : {mosi_s, rx_sh_q[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: the frame is bounded by synced CS_N edges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-state values: shifting, reloads, handshake and strobes.
    always_comb begin
        cnt_d     = cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        hold_d    = hold_q;
        full_d    = full_q;
        fresh_d   = fresh_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        rxv_d     = 1'b0;
        und_d     = 1'b0;
        abt_d     = 1'b0;
        reload    = 1'b0;

        if (state_q == IDLE) begin
            if (cs_fall) begin
                reload  = 1'b1;
                cnt_d   = '0;
                rx_sh_d = '0;
                oe_d    = 1'b1;
                miso_d  = first_bit(tx_src);
            end
        end else begin
            if (sample_e) begin
                rx_sh_d = rx_shifted;
                if (cnt_q == LAST) begin
                    rx_data_d = rx_shifted;
                    rxv_d     = 1'b1;
                    cnt_d     = '0;
                    // A word finishing as CS_N rises must not consume the holding reg.
                    reload    = !cs_rise;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // The first launch after a (re)load drives the first bit without shifting.
            if (launch_e) begin
                if (fresh_q) begin
                    miso_d  = first_bit(tx_sh_q);
                    fresh_d = 1'b0;
                end else begin
                    tx_sh_d = tx_shifted;
                    miso_d  = first_bit(tx_shifted);
                end
            end
            if (cs_rise) begin
                oe_d   = 1'b0;
                miso_d = 1'b0;
                abt_d  = (cnt_d != '0);
            end
        end

        if (reload) begin
            tx_sh_d = tx_src;
            und_d   = !full_q;
            full_d  = 1'b0;
            // On entry in CPHA=0 the first bit is already on the pin.
            fresh_d = (state_q == SHIFT) || (CPHA != 0);
        end

        if (tx_load && !full_q) begin
            hold_d = tx_data;
            full_d = 1'b1;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            hold_q    <= '0;
            full_q    <= 1'b0;
            fresh_q   <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            rxv_q     <= 1'b0;
            und_q     <= 1'b0;
            abt_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            fresh_q   <= fresh_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            rxv_q     <= rxv_d;
            und_q     <= und_d;
            abt_q     <= abt_d;
        end
    end

    assign spi_miso    = miso_q;
    assign miso_oe     = oe_q;
    assign tx_ready    = !full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rxv_q;
    assign underrun    = und_q;
    assign frame_abort = abt_q;
    assign busy        = (state_q == SHIFT);
endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word. It uses four instances covering the mode and width
// combinations: 0 = mode0 W8 MSB, 1 = mode3 W8 LSB, 2 = mode1 W8 LSB, 3 = mode2 W16 MSB.
module tb_spi_slave_word;
    localparam int HP = 6;  // SCLK half period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        ph = 1'b0;
    logic        mosi = 1'b0;
    logic [3:0]  cs_n = 4'hF;
    logic [3:0]  txl = 4'h0;
    logic [15:0] txd = 16'h0;
    logic [3:0]  sclk, miso, oe, txr, rxv, und, abt, bsy;
    logic [7:0]  rxd0, rxd1, rxd2;
    logic [15:0] rxd3;

    // ph is "clock active"; each instance sees it relative to its own CPOL.
    assign sclk = {4{ph}} ^ 4'b1010;

    spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u0 (
        .clk(clk), .reset(reset), .spi_sclk(sclk[0]), .spi_cs_n(cs_n[0]), .spi_mosi(mosi),
        .spi_miso(miso[0]), .miso_oe(oe[0]), .tx_data(txd[7:0]), .tx_load(txl[0]),
        .tx_ready(txr[0]), .rx_data(rxd0), .rx_valid(rxv[0]), .underrun(und[0]),
        .frame_abort(abt[0]), .busy(bsy[0]));
    spi_slave_word #(.WIDTH(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
        .clk(clk), .reset(reset), .spi_sclk(sclk[1]), .spi_cs_n(cs_n[1]), .spi_mosi(mosi),
        .spi_miso(miso[1]), .miso_oe(oe[1]), .tx_data(txd[7:0]), .tx_load(txl[1]),
        .tx_ready(txr[1]), .rx_data(rxd1), .rx_valid(rxv[1]), .underrun(und[1]),
        .frame_abort(abt[1]), .busy(bsy[1]));
    spi_slave_word #(.WIDTH(8), .CPOL(0), .CPHA(1), .MSB_FIRST(0)) u2 (
        .clk(clk), .reset(reset), .spi_sclk(sclk[2]), .spi_cs_n(cs_n[2]), .spi_mosi(mosi),
        .spi_miso(miso[2]), .miso_oe(oe[2]), .tx_data(txd[7:0]), .tx_load(txl[2]),
        .tx_ready(txr[2]), .rx_data(rxd2), .rx_valid(rxv[2]), .underrun(und[2]),
        .frame_abort(abt[2]), .busy(bsy[2]));
    spi_slave_word #(.WIDTH(16), .CPOL(1), .CPHA(0), .MSB_FIRST(1)) u3 (
        .clk(clk), .reset(reset), .spi_sclk(sclk[3]), .spi_cs_n(cs_n[3]), .spi_mosi(mosi),
        .spi_miso(miso[3]), .miso_oe(oe[3]), .tx_data(txd), .tx_load(txl[3]),
        .tx_ready(txr[3]), .rx_data(rxd3), .rx_valid(rxv[3]), .underrun(und[3]),
        .frame_abort(abt[3]), .busy(bsy[3]));

    int tests = 0;
    int fails = 0;
    int rxv_cnt[4] = '{default: 0};
    int und_cnt[4] = '{default: 0};
    int abt_cnt[4] = '{default: 0};
    logic [15:0] rx0_q[$];
    bit mo_q[$];
    bit mi_q[$];
    logic oe_mid, bsy_mid;

    // Strobe counters and a log of words delivered by instance 0.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rxv[k]) rxv_cnt[k] <= rxv_cnt[k] + 1;
            if (und[k]) und_cnt[k] <= und_cnt[k] + 1;
            if (abt[k]) abt_cnt[k] <= abt_cnt[k] + 1;
        end
        if (rxv[0]) rx0_q.push_back({8'h00, rxd0});
    end

    function automatic logic [15:0] rxd(input int k);
        case (k)
            0: return {8'h00, rxd0};
            1: return {8'h00, rxd1};
            2: return {8'h00, rxd2};
            default: return rxd3;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: the wire order of a word's bits.
    function automatic void push_word(input logic [15:0] w, input int width, input int msb);
        for (int i = 0; i < width; i++) mo_q.push_back(msb != 0 ? w[width-1-i] : w[i]);
    endfunction

    function automatic logic [15:0] miso_word(input int off, input int width, input int msb);
        logic [15:0] r = '0;
        for (int i = 0; i < width; i++) begin
            if (msb != 0) r[width-1-i] = mi_q[off+i];
            else          r[i] = mi_q[off+i];
        end
        return r;
    endfunction

    // Master: sends mo_q, captures MISO on every sample edge into mi_q.
    task automatic spi_bits(input int k, input int cpha, input int nbits);
        mi_q.delete();
        mosi = (cpha == 0 && nbits > 0) ? mo_q[0] : 1'b0;
        cs_n[k] = 1'b0;
        wclk(HP);
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 0) begin
                mi_q.push_back(miso[k]);
                if (i == 0) begin oe_mid = oe[k]; bsy_mid = bsy[k]; end
                ph = 1'b1; wclk(HP);
                ph = 1'b0; mosi = (i + 1 < nbits) ? mo_q[i+1] : 1'b0; wclk(HP);
            end else begin
                ph = 1'b1; mosi = mo_q[i]; wclk(HP);
                mi_q.push_back(miso[k]);
                if (i == 0) begin oe_mid = oe[k]; bsy_mid = bsy[k]; end
                ph = 1'b0; wclk(HP);
            end
        end
        wclk(HP);
        cs_n[k] = 1'b1;
        wclk(HP);
    endtask

    task automatic load(input int k, input logic [15:0] w);
        txd = w; txl[k] = 1'b1; wclk(1); txl[k] = 1'b0;
    endtask

    // One full single-word frame. have_tx says whether the holding reg is full at
    // frame start. Underruns = word starts (entry + reload at word end) minus loaded words.
    task automatic word_test(input int k, input int cpha, input int width, input int msb,
                             input logic [15:0] txw, input logic [15:0] rxw, input bit have_tx);
        int rv0 = rxv_cnt[k], ud0 = und_cnt[k], ab0 = abt_cnt[k];
        string t = $sformatf("u%0d_%h_%h", k, txw, rxw);
        mo_q.delete();
        push_word(rxw, width, msb);
        spi_bits(k, cpha, width);
        chk({t, "_rx"}, 32'(rxd(k)), 32'(rxw));
        chk({t, "_miso"}, 32'(miso_word(0, width, msb)), have_tx ? 32'(txw) : 32'h0);
        chk({t, "_rxv"}, rxv_cnt[k] - rv0, 1);
        chk({t, "_und"}, und_cnt[k] - ud0, have_tx ? 1 : 2);
        chk({t, "_abt"}, abt_cnt[k] - ab0, 0);
        chk({t, "_oe_bsy_mid"}, {oe_mid, bsy_mid}, 2'b11);
        chk({t, "_after"}, {oe[k], bsy[k], miso[k], txr[k]}, 4'b0001);
    endtask

    initial begin
        logic [15:0] a, b, c, prev;
        int rv0, ud0, ab0, qn;

        // Reset state of every instance.
        wclk(3);
        chk("rst_txr", txr, 4'hF);
        chk("rst_miso_oe", {miso, oe}, 8'h00);
        chk("rst_strobes", {rxv, und, abt}, 12'h000);
        chk("rst_busy", bsy, 4'h0);
        chk("rst_rxd", {rxd0, rxd1, rxd2, rxd3}, 40'h0);
        reset = 1'b0;
        wclk(4);

        // Mode 0, fixed then random words.
        load(0, 16'h3C);
        chk("u0_txr_after_load", txr[0], 1'b0);
        word_test(0, 0, 8, 1, 16'h3C, 16'hA5, 1);
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
            load(0, a);
            word_test(0, 0, 8, 1, a, b, 1);
        end

        // Mode 3 and mode 1, LSB first.
        load(1, 16'h7E); word_test(1, 1, 8, 0, 16'h7E, 16'h81, 1);
        load(2, 16'h7E); word_test(2, 1, 8, 0, 16'h7E, 16'h81, 1);
        for (int i = 0; i < 2; i++) begin
            a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
            load(1, a); word_test(1, 1, 8, 0, a, b, 1);
            a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
            load(2, a); word_test(2, 1, 8, 0, a, b, 1);
        end

        // Back-to-back words with only the first tx word loaded.
        a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
        c = 16'($urandom_range(0, 255));
        rv0 = rxv_cnt[0]; ud0 = und_cnt[0]; qn = rx0_q.size();
        load(0, a);
        mo_q.delete(); push_word(b, 8, 1); push_word(c, 8, 1);
        spi_bits(0, 0, 16);
        chk("b2b_rxv", rxv_cnt[0] - rv0, 2);
        chk("b2b_rx_w1", (rx0_q.size() > qn) ? 32'(rx0_q[qn]) : 32'hDEAD, 32'(b));
        chk("b2b_rx_w2", 32'(rxd0), 32'(c));
        chk("b2b_miso_w1", 32'(miso_word(0, 8, 1)), 32'(a));
        chk("b2b_miso_w2", 32'(miso_word(8, 8, 1)), 32'h0);
        chk("b2b_und", und_cnt[0] - ud0, 2);

        // CS_N raised after 5 bits.
        prev = {8'h00, rxd0}; rv0 = rxv_cnt[0]; ab0 = abt_cnt[0];
        mo_q.delete(); push_word(16'($urandom_range(0, 255)), 8, 1);
        spi_bits(0, 0, 5);
        chk("abort_pulse", abt_cnt[0] - ab0, 1);
        chk("abort_no_rxv", rxv_cnt[0] - rv0, 0);
        chk("abort_rxd_kept", 32'(rxd0), 32'(prev));
        chk("abort_idle", {bsy[0], oe[0]}, 2'b00);

        // Reset asserted mid-word, CS_N still low after release.
        load(0, 16'h5A);
        mosi = 1'b1; cs_n[0] = 1'b0; wclk(HP);
        for (int i = 0; i < 3; i++) begin ph = 1'b1; wclk(HP); ph = 1'b0; wclk(HP); end
        ph = 1'b1; wclk(2);
        reset = 1'b1; wclk(2);
        chk("midrst_outs", {rxd0, bsy[0], oe[0], miso[0], txr[0], rxv[0], und[0], abt[0]},
            {8'h00, 7'b0001000});
        reset = 1'b0; wclk(3);
        ph = 1'b0; wclk(HP); ph = 1'b1; wclk(HP); ph = 1'b0; wclk(HP);
        chk("midrst_ignored", {bsy[0], oe[0]}, 2'b00);
        cs_n[0] = 1'b1; wclk(HP);
        a = 16'($urandom_range(0, 255)); b = 16'($urandom_range(0, 255));
        load(0, a);
        word_test(0, 0, 8, 1, a, b, 1);

        // WIDTH=16 mode 2; a load while the holding reg is full is dropped.
        load(3, 16'h1234);
        chk("u3_txr_full", txr[3], 1'b0);
        load(3, 16'h5555);
        chk("u3_txr_still_full", txr[3], 1'b0);
        word_test(3, 0, 16, 1, 16'h1234, 16'hBEEF, 1);
        word_test(3, 0, 16, 1, 16'h0, 16'($urandom_range(0, 65535)), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
